// File: rtl/sram_two_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Optional statistics counters are enabled with SRAM_ARB_STATS_EN.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    localparam int unsigned VGA_PORT  = 0;
    localparam int unsigned LOAD_PORT = 1;

endpackage

// File: rtl/sram_two_port_arbiter_if.sv
// Client-side bus of the SRAM arbiter: per-port requests in, grant and read return out.
interface sram_two_port_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        req_i;
    logic [1:0]        lock_i;
    logic [1:0]        we_n_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        gnt_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        rvalid_o;

    modport master (
        output req_i, lock_i, we_n_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
        input  gnt_o, rdata_o, rvalid_o
    );

    modport slave (
        input  req_i, lock_i, we_n_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
        output gnt_o, rdata_o, rvalid_o
    );
endinterface

// File: rtl/sram_rd_tag_pipe.sv
// Read tag delay line: a tag pushed in a grant cycle emerges DEPTH cycles later.
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic    Clock,
    input  logic    Resetn,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_two_port_arbiter.sv
// Fixed-priority SRAM arbiter (VGA over loader) with burst lock and starvation guard.
// Define SRAM_ARB_STATS_EN to add saturating grant/force statistics outputs.
module sram_two_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    sram_two_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]      SRAM_address_o,
    output logic [DATA_W-1:0]      SRAM_write_data_o,
    output logic                   SRAM_we_n_o,
    input  logic [DATA_W-1:0]      SRAM_read_data_i
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]            gnt_cnt0_o,
    output logic [15:0]            gnt_cnt1_o,
    output logic [15:0]            force_cnt_o
`endif
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    arb_state_t       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [1:0]       gnt;
    logic             forced;
    rd_tag_t          tag_in, tag_out;

    always_comb begin
        gnt    = 2'b00;
        forced = 1'b0;
        // Grants are suppressed while reset is held so nothing is issued into a reset edge.
        if (!Resetn) begin
            gnt = 2'b00;
        end else if (state_q == S_OWN0 && bus.lock_i[VGA_PORT] && bus.req_i[VGA_PORT]) begin
            gnt = 2'b01;
        end else if (state_q == S_OWN1 && bus.lock_i[LOAD_PORT] && bus.req_i[LOAD_PORT]) begin
            gnt = 2'b10;
        end else if (wait_q == WaitW'(MAX_WAIT) && bus.req_i[LOAD_PORT]) begin
            gnt    = 2'b10;
            forced = 1'b1;
        end else if (bus.req_i[VGA_PORT]) begin
            gnt = 2'b01;
        end else if (bus.req_i[LOAD_PORT]) begin
            gnt = 2'b10;
        end

        state_d = S_IDLE;
        if (gnt[VGA_PORT]) begin
            state_d = S_OWN0;
        end else if (gnt[LOAD_PORT]) begin
            state_d = S_OWN1;
        end

        wait_d = wait_q;
        if (!bus.req_i[LOAD_PORT] || gnt[LOAD_PORT]) begin
            wait_d = '0;
        end else if (wait_q != WaitW'(MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
        end else if (gnt[VGA_PORT]) begin
            SRAM_address_o    <= bus.addr0_i;
            SRAM_write_data_o <= bus.wdata0_i;
            SRAM_we_n_o       <= bus.we_n_i[VGA_PORT];
        end else if (gnt[LOAD_PORT]) begin
            SRAM_address_o    <= bus.addr1_i;
            SRAM_write_data_o <= bus.wdata1_i;
            SRAM_we_n_o       <= bus.we_n_i[LOAD_PORT];
        end else begin
            SRAM_we_n_o       <= 1'b1;
        end
    end

    always_comb begin
        tag_in.port  = gnt[LOAD_PORT];
        tag_in.valid = gnt[VGA_PORT]  ? bus.we_n_i[VGA_PORT]  :
                       gnt[LOAD_PORT] ? bus.we_n_i[LOAD_PORT] : 1'b0;
    end

    sram_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .Clock  (Clock),
        .Resetn (Resetn),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    // Gating with Resetn drops the read that would land in the reset cycle itself.
    always_comb begin
        bus.rvalid_o = 2'b00;
        if (Resetn && tag_out.valid) begin
            bus.rvalid_o = tag_out.port ? 2'b10 : 2'b01;
        end
    end

    assign bus.gnt_o   = gnt;
    assign bus.rdata_o = SRAM_read_data_i;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt1_q, force_cnt_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            gnt_cnt0_q  <= '0;
            gnt_cnt1_q  <= '0;
            force_cnt_q <= '0;
        end else begin
            if (gnt[VGA_PORT] && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            if (gnt[LOAD_PORT] && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
            if (forced && force_cnt_q != 16'hFFFF) force_cnt_q <= force_cnt_q + 16'd1;
        end
    end

    assign gnt_cnt0_o  = gnt_cnt0_q;
    assign gnt_cnt1_o  = gnt_cnt1_q;
    assign force_cnt_o = force_cnt_q;
`endif

endmodule

// File: tb/tb_sram_two_port_arbiter.sv
// Scoreboard bench for sram_two_port_arbiter: directed stimulus, queued expectations,
// and a monitor that checks every read return and SRAM write strobe.
module tb_sram_two_port_arbiter;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int unsigned RL = 3;
    localparam int unsigned MW = 15;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic [AW-1:0] SRAM_address_o;
    logic [DW-1:0] SRAM_write_data_o;
    logic          SRAM_we_n_o;
    logic [DW-1:0] SRAM_read_data_i;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]   gnt_cnt0_o, gnt_cnt1_o, force_cnt_o;
`endif

    sram_two_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_two_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL),
        .MAX_WAIT     (MW)
    ) dut (
        .Clock             (Clock),
        .Resetn            (Resetn),
        .bus               (bus),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i)
`ifdef SRAM_ARB_STATS_EN
        ,
        .gnt_cnt0_o        (gnt_cnt0_o),
        .gnt_cnt1_o        (gnt_cnt1_o),
        .force_cnt_o       (force_cnt_o)
`endif
    );

    always #10 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // SRAM controller model: data for the registered address appears two cycles later.
    logic [AW-1:0] m1 = '0, m2 = '0;
    always @(posedge Clock) begin
        m1 <= SRAM_address_o;
        m2 <= m1;
    end

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {14'b0, a[17:16]};
    endfunction

    assign SRAM_read_data_i = mem_f(m2);

    typedef struct {
        int unsigned   due;
        logic          port;
        logic [DW-1:0] data;
    } rd_exp_t;

    typedef struct {
        int unsigned   due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];
    rd_exp_t mr;
    wr_exp_t mw;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read return or a write strobe.
    always @(negedge Clock) begin
        while (rq.size() > 0 && rq[0].due < cyc) begin
            mr = rq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rvalid_missing: got none expected port %0d due cycle %0d", mr.port,
                     mr.due);
        end
        if (bus.rvalid_o != 2'b00) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_unexpected: got %b expected 00 at cycle %0d",
                         bus.rvalid_o, cyc);
            end else begin
                mr = rq.pop_front();
                check("rvalid_port", {30'b0, bus.rvalid_o}, mr.port ? 32'd2 : 32'd1);
                check("rdata", {16'b0, bus.rdata_o}, {16'b0, mr.data});
                check("rvalid_cycle", cyc, mr.due);
            end
        end
        while (wq.size() > 0 && wq[0].due < cyc) begin
            mw = wq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL write_missing: got none expected addr %h due cycle %0d", mw.addr,
                     mw.due);
        end
        if (SRAM_we_n_o === 1'b0) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL write_unexpected: got we_n 0 expected 1 at cycle %0d", cyc);
            end else begin
                mw = wq.pop_front();
                check("write_addr", {14'b0, SRAM_address_o}, {14'b0, mw.addr});
                check("write_data", {16'b0, SRAM_write_data_o}, {16'b0, mw.data});
                check("write_cycle", cyc, mw.due);
            end
        end
    end

    task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we_n,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req_i    = req;
        bus.lock_i   = lock;
        bus.we_n_i   = we_n;
        bus.addr0_i  = a0;
        bus.addr1_i  = a1;
        bus.wdata0_i = d0;
        bus.wdata1_i = d1;
    endtask

    task automatic drive_idle();
        drive(2'b00, 2'b00, 2'b11, '0, '0, '0, '0);
    endtask

    // Checks the grant of the current cycle and queues the response it should produce.
    task automatic cycle_chk(input string name, input logic [1:0] exp_gnt, input bit push);
        rd_exp_t r;
        wr_exp_t w;
        logic    p;
        @(negedge Clock);
        check(name, {30'b0, bus.gnt_o}, {30'b0, exp_gnt});
        if (push && exp_gnt != 2'b00) begin
            p = exp_gnt[1];
            if (bus.we_n_i[p]) begin
                r.due  = cyc + RL;
                r.port = p;
                r.data = mem_f(p ? bus.addr1_i : bus.addr0_i);
                rq.push_back(r);
            end else begin
                w.due  = cyc + 1;
                w.addr = p ? bus.addr1_i : bus.addr0_i;
                w.data = p ? bus.wdata1_i : bus.wdata0_i;
                wq.push_back(w);
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) cycle_chk("idle_gnt", 2'b00, 1'b1);
    endtask

    initial begin
        Resetn = 1'b0;
        drive_idle();
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1'b1;

        // Reset state held over ten request-free cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("rst_gnt", {30'b0, bus.gnt_o}, 32'd0);
            check("rst_we_n", {31'b0, SRAM_we_n_o}, 32'd1);
            check("rst_rvalid", {30'b0, bus.rvalid_o}, 32'd0);
            check("rst_addr", {14'b0, SRAM_address_o}, 32'd0);
            @(posedge Clock);
            #1;
        end

        // Simultaneous reads: port 0 wins, address registered next cycle.
        drive(2'b11, 2'b00, 2'b11, 18'h00010, 18'h00020, 16'h0, 16'h0);
        cycle_chk("both_req_gnt", 2'b01, 1'b1);
        drive_idle();
        check("both_req_addr", {14'b0, SRAM_address_o}, 32'h00010);
        check("both_req_we_n", {31'b0, SRAM_we_n_o}, 32'd1);
        idle_cycles(5);

        // Port-0 burst lock holds off port 1 for three grants.
        drive(2'b11, 2'b01, 2'b11, 18'h00100, 18'h00030, 16'h0, 16'h0);
        cycle_chk("lock_gnt0", 2'b01, 1'b1);
        drive(2'b11, 2'b01, 2'b11, 18'h00101, 18'h00030, 16'h0, 16'h0);
        cycle_chk("lock_gnt1", 2'b01, 1'b1);
        drive(2'b11, 2'b01, 2'b11, 18'h00102, 18'h00030, 16'h0, 16'h0);
        cycle_chk("lock_gnt2", 2'b01, 1'b1);
        drive(2'b10, 2'b00, 2'b11, 18'h00103, 18'h00030, 16'h0, 16'h0);
        cycle_chk("lock_release", 2'b10, 1'b1);
        idle_cycles(1);

        // Lock raised by the non-owner is ignored.
        drive(2'b01, 2'b00, 2'b11, 18'h00104, 18'h00031, 16'h0, 16'h0);
        cycle_chk("own0_gnt", 2'b01, 1'b1);
        drive(2'b11, 2'b10, 2'b11, 18'h00105, 18'h00031, 16'h0, 16'h0);
        cycle_chk("nonowner_lock", 2'b01, 1'b1);
        idle_cycles(5);

        // Starvation guard: port 1 forced on its 16th request cycle, and again 16 later.
        for (int i = 0; i < 32; i++) begin
            drive(2'b11, 2'b00, 2'b11, 18'h00200 + 18'(i), 18'h00300 + 18'(i), 16'h0, 16'h0);
            cycle_chk("starve_gnt", (i == 15 || i == 31) ? 2'b10 : 2'b01, 1'b1);
        end
        idle_cycles(5);

        // Port-1 write at the top address: one strobe, no read return.
        drive(2'b10, 2'b00, 2'b01, 18'h00000, 18'h3FFFF, 16'h0, 16'hABCD);
        cycle_chk("write_gnt", 2'b10, 1'b1);
        idle_cycles(5);

        // Alternating reads, then reset before any of them returns.
        drive(2'b01, 2'b00, 2'b11, 18'h00040, 18'h00041, 16'h1111, 16'h2222);
        cycle_chk("alt_gnt0", 2'b01, 1'b0);
        drive(2'b10, 2'b00, 2'b11, 18'h00040, 18'h00041, 16'h1111, 16'h2222);
        cycle_chk("alt_gnt1", 2'b10, 1'b0);
        drive(2'b01, 2'b00, 2'b11, 18'h00042, 18'h00041, 16'h1111, 16'h2222);
        cycle_chk("alt_gnt2", 2'b01, 1'b0);
        drive(2'b11, 2'b00, 2'b11, 18'h00043, 18'h00044, 16'h1111, 16'h2222);
        Resetn = 1'b0;
        @(negedge Clock);
        check("rstcyc_gnt", {30'b0, bus.gnt_o}, 32'd0);
        check("rstcyc_rvalid", {30'b0, bus.rvalid_o}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        drive_idle();
        check("post_rst_addr", {14'b0, SRAM_address_o}, 32'd0);
        check("post_rst_wdata", {16'b0, SRAM_write_data_o}, 32'd0);
        check("post_rst_we_n", {31'b0, SRAM_we_n_o}, 32'd1);
        check("post_rst_rvalid", {30'b0, bus.rvalid_o}, 32'd0);
        idle_cycles(6);

        check("rd_queue_empty", rq.size(), 32'd0);
        check("wr_queue_empty", wq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_two_port_arbiter.md
Name: sram_two_port_arbiter

Overview:
- Shares the single external SRAM controller between two requesters:
  - port 0: VGA pixel fetch. Real-time, high priority, read-only in practice.
  - port 1: UART image loader / host writer. Background, low priority, read or write.
- Sits between the client units and the SRAM controller in the top level.
- Fixed priority with a starvation guard and a burst lock, so the VGA can fetch an R/G/B word triplet without interruption.
- Read data is routed back to the issuing port through a tag pipeline.

Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, SRAM data width
- READ_LATENCY, 3, cycles from grant cycle to read data valid at the SRAM controller output
- MAX_WAIT, 15, consecutive denied cycles on port 1 before a forced port-1 grant

Ports:
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  synchronous active-low reset
- req_i[1:0]  in  2  per-port request
- lock_i[1:0]  in  2  per-port burst lock; honoured only while that port owns the SRAM
- we_n_i[1:0]  in  2  per-port write enable, active low
- addr0_i, addr1_i  in  ADDR_W each  per-port address
- wdata0_i, wdata1_i  in  DATA_W each  per-port write data
- gnt_o[1:0]  out  2  one-hot grant; the request is accepted in the cycle gnt is high
- rdata_o  out  DATA_W  read data, shared by both ports
- rvalid_o[1:0]  out  2  per-port read-data-valid strobe
- SRAM_address_o  out  ADDR_W  registered address to the SRAM controller
- SRAM_write_data_o  out  DATA_W  registered write data
- SRAM_we_n_o  out  1  registered write enable, active low
- SRAM_read_data_i  in  DATA_W  read data from the SRAM controller

Behaviour:
- Reset, synchronous, Resetn=0 at a rising edge:
  - gnt_o=0, rvalid_o=0, SRAM_we_n_o=1, SRAM_address_o=0, SRAM_write_data_o=0
  - state=S_IDLE, wait_cnt=0, tag pipeline cleared
- Reset mid-burst: in-flight reads are dropped and no rvalid is emitted for them.
- Arbiter state machine: S_IDLE, S_OWN0, S_OWN1.
- gnt_o is combinational from req_i, lock_i, the state and the starvation flag. At most one bit is high. A grant is issued only to a requesting port.
- Priority decision each cycle, evaluated in this order:
  - If the current owner has lock=1 and req=1, the owner is granted.
  - Otherwise, if wait_cnt==MAX_WAIT and req_i[1]=1, port 1 is granted.
  - Otherwise port 0 is granted if it is requesting, else port 1 if it is requesting.
  - With no request: state returns to S_IDLE and no grant is issued.
- The state tracks the last granted port (S_OWN0/S_OWN1).
- A lock asserted by a non-owner is ignored.
- Lock held with req=0: ownership is released the same cycle.
- wait_cnt:
  - increments, saturating at MAX_WAIT, when req_i[1]=1 and gnt_o[1]=0
  - clears on any port-1 grant or when req_i[1]=0
  - the forced grant overrides port 0 even if port 0 requests in the same cycle, but not an active port-0 lock
- Issue: in a grant cycle, the granted port's addr/wdata/we_n are registered onto the SRAM_* outputs at the next edge.
- Idle cycles: SRAM_we_n_o=1; address and data hold their last values.
- Tag pipeline, READ_LATENCY deep:
  - carries {valid, port}; pushed as valid in every read-grant cycle, as invalid otherwise
  - rvalid_o[port] pulses exactly READ_LATENCY cycles after the grant cycle
  - rdata_o = SRAM_read_data_i passthrough
- Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
- Writes generate no rvalid.
- Throughput: one access per cycle maximum; there are no turnaround cycles.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0_o, gnt_cnt1_o, force_cnt_o, 16 bits each, saturating.
  - the grant counters count grant cycles per port
  - force_cnt counts starvation-forced grants
  - all three clear on reset
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package sram_arb_pkg:
  - state enum arb_state_t {S_IDLE, S_OWN0, S_OWN1}
  - struct rd_tag_t {valid, port}
  - port index constants VGA_PORT=0, LOAD_PORT=1
- Sub-module sram_rd_tag_pipe: parameterised shift register of rd_tag_t. Clock, Resetn, push tag in, tag out at READ_LATENCY.

Test Plan:
- Reset, then no requests for 10 cycles -> gnt_o=0, SRAM_we_n_o=1, rvalid_o=0, SRAM_address_o=0.
- req_i=2'b11 for one cycle, addr0=0x00010, addr1=0x00020, both reads -> gnt_o=2'b01; SRAM_address_o=0x00010 next cycle; rvalid_o=2'b01 exactly 3 cycles after the grant.
- Port 0 holds lock=1 and req=1 for 3 cycles at addresses 0x100..0x102 while port 1 requests -> three consecutive port-0 grants, then gnt_o=2'b10 on the 4th cycle.
- Port 0 requests continuously without lock; port 1 requests from cycle 0 -> port 1 granted on its 16th request cycle (wait_cnt reaches 15); wait_cnt returns to 0 afterwards.
- Port-1 write addr=0x3FFFF, data=0xABCD -> SRAM_we_n_o=0 for exactly one cycle with that address and data; no rvalid on either port.
- Alternating reads P0,P1,P0 on consecutive cycles, then Resetn=0 one cycle after the last grant -> the first rvalid is absent; all outputs hold reset values; no stale rvalid after reset release.
